shifter_pipe: RTL
=================

SHIFTER_PIPE -- requirements
Module: shifter_pipe

Interface
REQ-001 SHALL have parameter N, default 32: data width in bits; legal values are powers of 2, 8..64.
REQ-002 SHALL have localparam S = clog2(N): stage count and shift-amount width (5 when N=32).
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1: operand beat offered.
REQ-006 SHALL have port in_ready, output, 1: the block accepts a beat this cycle.
REQ-007 SHALL have port in_a, input, N: operand to shift.
REQ-008 SHALL have port in_b, input, N: shift amount; only in_b[S-1:0] is used.
REQ-009 SHALL have port in_op, input, 2: mode; 00 SLL, 01 SRL, 10 SRA, 11 ROR (see Configuration).
REQ-010 SHALL have port out_valid, output, 1: result beat present.
REQ-011 SHALL have port out_ready, input, 1: consumer takes the result this cycle.
REQ-012 SHALL have port out_z, output, N: shift result.

Function
REQ-013 A beat SHALL transfer in when in_valid && in_ready, and out when out_valid && out_ready.
REQ-014 Datapath SHALL be S registered stages; stage k shifts by 2^k when the captured amount bit k = 1, else passes.
REQ-015 Latency SHALL be exactly S cycles from input transfer to out_valid, when there is no stall.
REQ-016 Stall: stall = out_valid && !out_ready; during a stall, every stage register SHALL hold its value.
REQ-017 in_ready SHALL equal !stall, combinationally, so that one beat per cycle is sustained when out_ready = 1.
REQ-018 Each stage SHALL carry a valid bit, its partial data, the remaining amount bits and op; a bubble (valid = 0) SHALL propagate and never assert out_valid.
REQ-019 SLL SHALL fill vacated positions with 0; SRL SHALL fill with 0; SRA SHALL fill with the captured in_a[N-1].
REQ-020 Amount bits in_b[N-1:S] SHALL be ignored; for example, with N=32, an amount of 37 shifts by 5.
REQ-021 Amount 0 SHALL return in_a unchanged in every mode.
REQ-022 Results SHALL leave in the order accepted; no beat is dropped or duplicated under any out_ready pattern.
REQ-023 out_z SHALL be held stable while out_valid = 1 and out_ready = 0.
REQ-024 in_a, in_b and in_op are don't-care when in_valid = 0.

Reset
REQ-025 While rst = 1, all stage valid bits SHALL clear, out_valid = 0, and out_z = 0 at the next edge.
REQ-026 Reset mid-operation SHALL discard all in-flight beats; no stale result SHALL appear after rst falls.
REQ-027 in_ready SHALL be 1 during and immediately after reset, because out_valid = 0.

Configuration
REQ-028 Macro SHIFTER_PIPE_ROTATE_EN SHALL compile rotate support in or out.
REQ-029 With SHIFTER_PIPE_ROTATE_EN defined, op 11 SHALL rotate right: each stage feeds the bits shifted out of position 0 back into the top.
REQ-030 With SHIFTER_PIPE_ROTATE_EN undefined, op 11 SHALL behave exactly as SRL and no rotate logic SHALL be synthesised.

Verification (N=32, S=5)
REQ-031 SLL: in_a=0x00000001, in_b=31 -> out_z=0x80000000 exactly 5 cycles after acceptance.
REQ-032 SRA/SRL: in_a=0x80000000, in_b=4; SRA -> 0xF8000000 and SRL -> 0x08000000; amount 37 with SLL on 0xFFFFFFFF -> 0xFFFFFFE0.
REQ-033 Backpressure: 8 back-to-back SLL beats with amounts 0..7 on in_a=1, out_ready low for cycles 6-9 -> results 1,2,4,...,128 in order, in_ready=0 during the stall, out_z stable.
REQ-034 Reset mid-flight: accept 3 beats, assert rst for 1 cycle on cycle 2 -> out_valid stays 0 until new beats arrive, and in_ready=1.
REQ-035 Rotate: op=11, in_a=0x00000001, in_b=1 -> 0x80000000 with SHIFTER_PIPE_ROTATE_EN, and 0x00000000 without it.

Source files
------------

// File: rtl/shifter_pipe.sv
// shifter_pipe: S-stage pipelined barrel shifter (SLL/SRL/SRA, optional ROR)
// with a valid/ready handshake on both sides. Stage k shifts by 2^k when
// amount bit k is set. A stalled output freezes the whole pipe.
// Optional feature: define SHIFTER_PIPE_ROTATE_EN to make op 11 rotate right;
// otherwise op 11 is a logical right shift.
module shifter_pipe #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_a,
   input  logic [N-1:0] in_b,
   input  logic [1:0]   in_op,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_z
);
   localparam int S = $clog2(N);

   // stage registers
   logic [S-1:0] vld;
   logic [N-1:0] dat [S];
   logic [S-1:0] amt [S];
   logic [1:0]   opr [S];

   // stage inputs (previous stage, or the input port for stage 0)
   logic [S-1:0] vs;
   logic [N-1:0] ds [S];
   logic [S-1:0] as [S];
   logic [1:0]   os [S];

   // next-state values for every stage
   logic [S-1:0] vld_n;
   logic [N-1:0] dat_n [S];
   logic [S-1:0] amt_n [S];
   logic [1:0]   opr_n [S];

   logic stall;

   // upper amount bits are ignored by design; last-stage amount/op have no consumer
   logic unused_bits;
   assign unused_bits = ^{in_b[N-1:S], amt[S-1], opr[S-1]};

   assign stall     = vld[S-1] && !out_ready;
   assign in_ready  = !stall;
   assign out_valid = vld[S-1];
   assign out_z     = dat[S-1];

   // one fixed-distance shift; SRA reuses the current top bit, which after an
   // arithmetic shift is still the original sign of the operand
   function automatic logic [N-1:0] stage_shift(input logic [N-1:0] d,
                                                input logic [1:0] op,
                                                input int unsigned sh);
      logic [N-1:0] r;
      case (op)
         2'b00:   r = d << sh;
         2'b10:   r = N'($signed(d) >>> sh);
`ifdef SHIFTER_PIPE_ROTATE_EN
         2'b11:   r = (d >> sh) | (d << (N - sh));
`endif
         default: r = d >> sh;
      endcase
      return r;
   endfunction

   // route stage inputs and compute each stage's next contents
   always_comb begin
      vs    = '0;
      vld_n = '0;
      vs[0] = in_valid;
      ds[0] = in_a;
      as[0] = in_b[S-1:0];
      os[0] = in_op;
      for (int k = 1; k < S; k++) begin
         vs[k] = vld[k-1];
         ds[k] = dat[k-1];
         as[k] = amt[k-1];
         os[k] = opr[k-1];
      end
      for (int k = 0; k < S; k++) begin
         vld_n[k] = vs[k];
         dat_n[k] = as[k][k] ? stage_shift(ds[k], os[k], 1 << k) : ds[k];
         amt_n[k] = as[k];
         opr_n[k] = os[k];
      end
   end

   // advance all stages together unless the output is stalled; reset flushes
   always_ff @(posedge clk) begin
      if (rst) begin
         vld <= '0;
         for (int k = 0; k < S; k++) begin
            dat[k] <= '0;
            amt[k] <= '0;
            opr[k] <= '0;
         end
      end else if (!stall) begin
         vld <= vld_n;
         for (int k = 0; k < S; k++) begin
            dat[k] <= dat_n[k];
            amt[k] <= amt_n[k];
            opr[k] <= opr_n[k];
         end
      end
   end
endmodule
